// File: rtl/mips_irq_pkg.sv
// Shared types and constants for the mips_16bit interrupt controller and
// the arbitration logic built from it.
package mips_irq_pkg;

    localparam int          IRQ_ID_W       = 4;
    localparam logic [15:0] VEC_BASE_DEF   = 16'h0040;
    localparam int          VEC_STRIDE_DEF = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } irq_state_e;

endpackage

// File: rtl/mips_irq_prio_enc.sv
// Fixed-priority encoder: the lowest set request bit wins.
// Purely combinational, so the caller gets a valid flag and index in the same cycle.
module mips_irq_prio_enc
    import mips_irq_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0]          req,
    output logic                  vld,
    output logic [IRQ_ID_W-1:0]   idx
);

    always_comb begin
        // NOTE: every output gets a default before the loop so no latch is inferred.
        vld = 1'b0;
        idx = '0;
        // Scan from the top down so the lowest index is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                vld = 1'b1;
                idx = IRQ_ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/mips_irq_controller.sv
// Interrupt controller for the mips_16bit core: sync/edge capture, mask,
// fixed-priority request/ack/eret handshake. Define IRQ_NEST_EN for one preemption level.
module mips_irq_controller
    import mips_irq_pkg::*;
#(
    parameter int          N_SRC      = 8,
    parameter logic [15:0] VEC_BASE   = VEC_BASE_DEF,
    parameter int          VEC_STRIDE = VEC_STRIDE_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_SRC-1:0]     irq_src,
    input  logic                 mask_wr,
    input  logic [N_SRC-1:0]     mask_wdata,
    output logic [N_SRC-1:0]     mask_q,
    output logic [N_SRC-1:0]     pending,
    output logic                 cpu_irq,
    input  logic                 cpu_irq_ack,
    input  logic                 cpu_eret,
    output logic [15:0]          irq_vector,
    output logic [IRQ_ID_W-1:0]  irq_id,
    output logic                 busy
);

    logic [N_SRC-1:0]    sync1, sync2, prev;
    logic [N_SRC-1:0]    edge_evt, pend_clr;
    logic                win_vld;
    logic [IRQ_ID_W-1:0] win_id;
    irq_state_e          state;

`ifdef IRQ_NEST_EN
    logic                saved_vld;
    logic [IRQ_ID_W-1:0] saved_id;
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
        end else begin
            sync1 <= irq_src;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign edge_evt = sync2 & ~prev;

    // Only the acknowledged source is cleared; a fresh edge on it still wins.
    always_comb begin
        pend_clr = '0;
        if (state == REQ && cpu_irq_ack)
            pend_clr = N_SRC'(1) << irq_id;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending <= '0;
            mask_q  <= '0;
        end else begin
            pending <= (pending & ~pend_clr) | edge_evt;
            if (mask_wr)
                mask_q <= mask_wdata;
        end
    end

    mips_irq_prio_enc #(.N(N_SRC)) u_prio_enc (
        .req (pending & mask_q),
        .vld (win_vld),
        .idx (win_id)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cpu_irq   <= 1'b0;
            irq_id    <= '0;
`ifdef IRQ_NEST_EN
            saved_vld <= 1'b0;
            saved_id  <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (win_vld) begin
                        state   <= REQ;
                        irq_id  <= win_id;
                        cpu_irq <= 1'b1;
                    end
                end
                REQ: begin
                    if (cpu_irq_ack) begin
                        state   <= SERVICE;
                        cpu_irq <= 1'b0;
                    end
                end
                SERVICE: begin
`ifdef IRQ_NEST_EN
                    // A return pops the preempted source before the controller goes idle.
                    if (cpu_eret) begin
                        if (saved_vld) begin
                            irq_id    <= saved_id;
                            saved_vld <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (!saved_vld && win_vld && (win_id < irq_id)) begin
                        saved_id  <= irq_id;
                        saved_vld <= 1'b1;
                        irq_id    <= win_id;
                        cpu_irq   <= 1'b1;
                        state     <= REQ;
                    end
`else
                    if (cpu_eret)
                        state <= IDLE;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy       = (state != IDLE);
    assign irq_vector = VEC_BASE + 16'(irq_id) * 16'(VEC_STRIDE);

endmodule

// File: tb/tb_mips_irq_controller.sv
// Bench for mips_irq_controller: directed scenarios plus random traffic, all
// checked every cycle against a transaction-level model of the controller.
module tb_mips_irq_controller;
    import mips_irq_pkg::*;

    localparam int N = 8;

`ifdef IRQ_NEST_EN
    localparam bit NEST = 1'b1;
`else
    localparam bit NEST = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                reset;
    logic [N-1:0]        irq_src;
    logic                mask_wr;
    logic [N-1:0]        mask_wdata;
    logic [N-1:0]        mask_q;
    logic [N-1:0]        pending;
    logic                cpu_irq;
    logic                cpu_irq_ack;
    logic                cpu_eret;
    logic [15:0]         irq_vector;
    logic [IRQ_ID_W-1:0] irq_id;
    logic                busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mips_irq_controller #(.N_SRC(N)) dut (
        .clk         (clk),
        .reset       (reset),
        .irq_src     (irq_src),
        .mask_wr     (mask_wr),
        .mask_wdata  (mask_wdata),
        .mask_q      (mask_q),
        .pending     (pending),
        .cpu_irq     (cpu_irq),
        .cpu_irq_ack (cpu_irq_ack),
        .cpu_eret    (cpu_eret),
        .irq_vector  (irq_vector),
        .irq_id      (irq_id),
        .busy        (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: phase 0 idle, 1 requesting, 2 in service; saved ids on a stack.
    logic [N-1:0] m_pending, m_mask;
    logic [N-1:0] hist [3];   // raw line samples from the last three edges, newest first
    int           m_phase, m_id;
    int           m_saved [$];

    function automatic int winner(input logic [N-1:0] v);
        for (int i = 0; i < N; i++)
            if (v[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_pending = '0;
        m_mask    = '0;
        for (int i = 0; i < 3; i++) hist[i] = '0;
        m_phase   = 0;
        m_id      = 0;
        m_saved.delete();
    endtask

    task automatic model_step();
        int           w;
        logic [N-1:0] arrivals, clr;
        if (!reset) begin
            model_reset();
        end else begin
            w        = winner(m_pending & m_mask);
            arrivals = hist[1] & ~hist[2];   // rising edge seen two edges ago
            clr      = '0;
            case (m_phase)
                0: if (w >= 0) begin m_phase = 1; m_id = w; end
                1: if (cpu_irq_ack) begin clr[m_id] = 1'b1; m_phase = 2; end
                default: begin
                    if (cpu_eret) begin
                        if (m_saved.size() > 0) m_id = m_saved.pop_back();
                        else m_phase = 0;
                    end else if (NEST && m_saved.size() == 0 && w >= 0 && w < m_id) begin
                        m_saved.push_back(m_id);
                        m_id    = w;
                        m_phase = 1;
                    end
                end
            endcase
            m_pending = (m_pending & ~clr) | arrivals;
            if (mask_wr) m_mask = mask_wdata;
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = irq_src;
        end
    endtask

    task automatic compare_all();
        check("pending",    32'(pending),    32'(m_pending));
        check("mask_q",     32'(mask_q),     32'(m_mask));
        check("cpu_irq",    32'(cpu_irq),    32'(m_phase == 1));
        check("busy",       32'(busy),       32'(m_phase != 0));
        check("irq_id",     32'(irq_id),     32'(m_id));
        check("irq_vector", 32'(irq_vector), 32'h0040 + 32'(m_id) * 4);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic write_mask(input logic [N-1:0] v);
        mask_wr = 1'b1; mask_wdata = v;
        tick();
        mask_wr = 1'b0;
    endtask

    task automatic pulse_ack();
        cpu_irq_ack = 1'b1; tick(); cpu_irq_ack = 1'b0;
    endtask

    task automatic pulse_eret();
        cpu_eret = 1'b1; tick(); cpu_eret = 1'b0;
    endtask

    initial begin
        model_reset();
        reset = 1'b0; irq_src = '1; mask_wr = 1'b0; mask_wdata = '0;
        cpu_irq_ack = 1'b0; cpu_eret = 1'b0;

        // 1. reset with all lines high, drop lines, then release
        repeat (3) tick();
        check("rst_vector", 32'(irq_vector), 32'h0040);
        check("rst_cpu_irq", 32'(cpu_irq), 32'h0);
        irq_src = '0;
        tick();
        reset = 1'b1;
        repeat (4) tick();
        check("post_rst_pending", 32'(pending), 32'h0);

        // 2. single source with exact latency
        write_mask(8'h08);
        irq_src[3] = 1'b1;
        tick(); tick();
        check("lat_pending_k1", 32'(pending), 32'h00);
        tick();
        check("lat_pending_k2", 32'(pending), 32'h08);
        check("lat_irq_k2", 32'(cpu_irq), 32'h0);
        tick();
        check("lat_irq_k3", 32'(cpu_irq), 32'h1);
        check("t2_id", 32'(irq_id), 32'd3);
        check("t2_vector", 32'(irq_vector), 32'h004C);
        irq_src = '0;
        pulse_ack();
        check("t2_ack_pending", 32'(pending), 32'h0);
        check("t2_ack_busy", 32'(busy), 32'h1);
        pulse_eret();
        check("t2_eret_busy", 32'(busy), 32'h0);

        // 3. simultaneous sources 5 and 2
        write_mask(8'hFF);
        irq_src = 8'h24;
        repeat (4) tick();
        check("t3_id_first", 32'(irq_id), 32'd2);
        check("t3_vec_first", 32'(irq_vector), 32'h0048);
        irq_src = '0;
        pulse_ack();
        pulse_eret();
        tick();
        check("t3_irq_second", 32'(cpu_irq), 32'h1);
        check("t3_vec_second", 32'(irq_vector), 32'h0054);
        pulse_ack();
        pulse_eret();

        // 4. request is frozen in REQ; masked event stays pending
        irq_src[4] = 1'b1;
        repeat (4) tick();
        irq_src = '0;
        tick();
        irq_src[1] = 1'b1;
        write_mask(8'h00);
        repeat (3) tick();
        check("t4_id_held", 32'(irq_id), 32'd4);
        check("t4_irq_held", 32'(cpu_irq), 32'h1);
        irq_src = '0;
        pulse_ack();
        pulse_eret();
        repeat (3) tick();
        check("t4_masked_pending", 32'(pending), 32'h02);
        check("t4_masked_no_irq", 32'(cpu_irq), 32'h0);

        // 5. stray handshake strobes, then reset in the middle of a request
        pulse_eret();
        check("t5_stray_eret", 32'(busy), 32'h0);
        write_mask(8'hFF);
        tick();
        check("t5_unmasked_id", 32'(irq_id), 32'd1);
        pulse_ack();
        pulse_ack();
        check("t5_stray_ack_busy", 32'(busy), 32'h1);
        pulse_eret();
        irq_src[6] = 1'b1;
        repeat (4) tick();
        irq_src = '0;
        reset = 1'b0;
        #1;
        model_reset();
        check("t5_rst_cpu_irq", 32'(cpu_irq), 32'h0);
        check("t5_rst_pending", 32'(pending), 32'h0);
        repeat (2) tick();
        reset = 1'b1;
        tick();

        // 6. preemption of source 6 by source 0
        write_mask(8'hFF);
        irq_src[6] = 1'b1;
        repeat (4) tick();
        irq_src = '0;
        pulse_ack();
        irq_src[0] = 1'b1;
        repeat (4) tick();
        irq_src = '0;
        if (NEST) begin
            check("t6_preempt_id", 32'(irq_id), 32'd0);
            check("t6_preempt_irq", 32'(cpu_irq), 32'h1);
            pulse_ack();
            pulse_eret();
            check("t6_pop_id", 32'(irq_id), 32'd6);
            check("t6_pop_busy", 32'(busy), 32'h1);
            pulse_eret();
            check("t6_done_busy", 32'(busy), 32'h0);
        end else begin
            check("t6_no_preempt_id", 32'(irq_id), 32'd6);
            check("t6_no_preempt_irq", 32'(cpu_irq), 32'h0);
            pulse_eret();
            tick();
            check("t6_later_id", 32'(irq_id), 32'd0);
            pulse_ack();
            pulse_eret();
        end

        // random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            reset = 1'b1;
            for (int b = 0; b < N; b++)
                if ($urandom_range(0, 15) == 0) irq_src[b] = ~irq_src[b];
            mask_wr     = ($urandom_range(0, 19) == 0);
            mask_wdata  = N'($urandom);
            cpu_irq_ack = (m_phase == 1) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
            cpu_eret    = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 499) == 0) begin
                reset = 1'b0;
                #1;
                model_reset();
                check("rnd_rst_cpu_irq", 32'(cpu_irq), 32'h0);
                check("rnd_rst_pending", 32'(pending), 32'h0);
            end
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
